// File: rtl/cpu_controller_pkg.sv
// Shared encodings for the accumulator CPU control unit: opcodes, ALU functions,
// FSM states and the packed control word driven to the datapath.
package cpu_ctrl_pkg;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_AND  = 2'b01;
    localparam logic [1:0] ALU_XOR  = 2'b10;
    localparam logic [1:0] ALU_PASS = 2'b11;

    typedef enum logic [1:0] {
        FETCH  = 2'b00,
        DECODE = 2'b01,
        EXEC   = 2'b10,
        HALTED = 2'b11
    } state_e;

    typedef struct packed {
        logic       jump;
        logic       skip;
        logic       mem_write;
        logic       mem_read;
        logic       acc_write;
        logic       alu_to_acc;
        logic [1:0] alu_op;
        logic       halt;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_IDLE  = '0;
    localparam ctrl_word_t CTRL_FETCH = '{mem_read: 1'b1, alu_op: ALU_ADD, default: 1'b0};
    localparam ctrl_word_t CTRL_HALT  = '{halt: 1'b1, alu_op: ALU_ADD, default: 1'b0};

endpackage

// File: rtl/cpu_controller_decode.sv
// Combinational EXEC-phase decoder: latched opcode to datapath control word.
// Unknown or X opcodes fall through to the all-zero word.
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [2:0] ir_op_i,
    output ctrl_word_t ctrl_o
);

    always_comb begin
        ctrl_o = CTRL_IDLE;
        case (ir_op_i)
            OP_HLT: ctrl_o.halt = 1'b1;
            OP_SKZ: ctrl_o.skip = 1'b1;
            OP_ADD: begin
                ctrl_o.mem_read   = 1'b1;
                ctrl_o.acc_write  = 1'b1;
                ctrl_o.alu_to_acc = 1'b1;
                ctrl_o.alu_op     = ALU_ADD;
            end
            OP_AND: begin
                ctrl_o.mem_read   = 1'b1;
                ctrl_o.acc_write  = 1'b1;
                ctrl_o.alu_to_acc = 1'b1;
                ctrl_o.alu_op     = ALU_AND;
            end
            OP_XOR: begin
                ctrl_o.mem_read   = 1'b1;
                ctrl_o.acc_write  = 1'b1;
                ctrl_o.alu_to_acc = 1'b1;
                ctrl_o.alu_op     = ALU_XOR;
            end
            // LDA routes memory data straight into the accumulator
            OP_LDA: begin
                ctrl_o.mem_read   = 1'b1;
                ctrl_o.acc_write  = 1'b1;
                ctrl_o.alu_to_acc = 1'b0;
                ctrl_o.alu_op     = ALU_PASS;
            end
            OP_STO: ctrl_o.mem_write = 1'b1;
            OP_JMP: ctrl_o.jump      = 1'b1;
            default: ctrl_o = CTRL_IDLE;
        endcase
    end

endmodule

// File: rtl/cpu_controller.sv
// FETCH/DECODE/EXEC/HALTED sequencer for the accumulator CPU; Moore outputs held in a register.
// Optional macro CTRL_SKZ_GATE_EN adds the zero input and gates skip inside the controller.
module cpu_controller
    import cpu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] opcode,
`ifdef CTRL_SKZ_GATE_EN
    input  logic       zero,
`endif
    output logic       jump,
    output logic       skip,
    output logic       memWrite,
    output logic       memRead,
    output logic       ACCwrite,
    output logic       ALUtoACC,
    output logic [1:0] ALU_OP,
    output logic       Halt
);

    state_e     state_q, state_d;
    logic [2:0] ir_op_q, ir_op_d;
    ctrl_word_t out_q, out_d;
    ctrl_word_t exec_word;

    ctrl_decode u_decode (
        .ir_op_i (ir_op_d),
        .ctrl_o  (exec_word)
    );

    always_comb begin
        state_d = state_q;
        ir_op_d = ir_op_q;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                state_d = EXEC;
                ir_op_d = opcode;
            end
            EXEC: begin
                if (ir_op_q == OP_HLT) state_d = HALTED;
                else                   state_d = FETCH;
            end
            HALTED: state_d = HALTED;
            default: state_d = FETCH;
        endcase
    end

    // Output word is computed from the next state so the register holds the Moore value of state_q
    always_comb begin
        out_d = CTRL_IDLE;
        case (state_d)
            FETCH:   out_d = CTRL_FETCH;
            DECODE:  out_d = CTRL_IDLE;
            EXEC:    out_d = exec_word;
            HALTED:  out_d = CTRL_HALT;
            default: out_d = CTRL_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH;
            ir_op_q <= 3'b000;
            out_q   <= CTRL_FETCH;
        end else begin
            state_q <= state_d;
            ir_op_q <= ir_op_d;
            out_q   <= out_d;
        end
    end

    assign jump     = out_q.jump;
`ifdef CTRL_SKZ_GATE_EN
    assign skip     = out_q.skip & zero;
`else
    assign skip     = out_q.skip;
`endif
    assign memWrite = out_q.mem_write;
    assign memRead  = out_q.mem_read;
    assign ACCwrite = out_q.acc_write;
    assign ALUtoACC = out_q.alu_to_acc;
    assign ALU_OP   = out_q.alu_op;
    assign Halt     = out_q.halt;

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller; covers CTRL_SKZ_GATE_EN when that macro is defined.
module tb_cpu_controller;

    logic       clk;
    logic       rst_n;
    logic [2:0] opcode;
    logic       zero;
    logic       jump, skip, memWrite, memRead, ACCwrite, ALUtoACC, Halt;
    logic [1:0] ALU_OP;

    int errors = 0;
    int checks = 0;

    // Expected words: {jump, skip, memWrite, memRead, ACCwrite, ALUtoACC, ALU_OP[1:0], Halt}
    localparam logic [8:0] W_FETCH = 9'b000100000;
    localparam logic [8:0] W_IDLE  = 9'b000000000;
    localparam logic [8:0] W_HLT   = 9'b000000001;
    localparam logic [8:0] W_SKZ   = 9'b010000000;
    localparam logic [8:0] W_ADD   = 9'b000111000;
    localparam logic [8:0] W_AND   = 9'b000111010;
    localparam logic [8:0] W_XOR   = 9'b000111100;
    localparam logic [8:0] W_LDA   = 9'b000110110;
    localparam logic [8:0] W_STO   = 9'b001000000;
    localparam logic [8:0] W_JMP   = 9'b100000000;

    cpu_controller dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .opcode   (opcode),
`ifdef CTRL_SKZ_GATE_EN
        .zero     (zero),
`endif
        .jump     (jump),
        .skip     (skip),
        .memWrite (memWrite),
        .memRead  (memRead),
        .ACCwrite (ACCwrite),
        .ALUtoACC (ALUtoACC),
        .ALU_OP   (ALU_OP),
        .Halt     (Halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [8:0] exp);
        logic [8:0] obs;
        obs = {jump, skip, memWrite, memRead, ACCwrite, ALUtoACC, ALU_OP, Halt};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance one clock and land on the following falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Starts at FETCH, runs one full instruction and returns at the next FETCH
    task automatic run_instr(input string tag, input logic [2:0] op, input logic [8:0] exp);
        check({tag, "_fetch"}, W_FETCH);
        opcode = ~op;
        tick();
        check({tag, "_decode"}, W_IDLE);
        opcode = op;
        tick();
        check({tag, "_exec"}, exp);
        opcode = ~op;
        tick();
    endtask

    initial begin
        rst_n  = 1'b0;
        opcode = 3'b111;
        zero   = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("reset_fetch", W_FETCH);
        rst_n = 1'b1;
        tick();
        check("reset_decode", W_IDLE);

        // Glitch: SKZ latched in DECODE, later opcode changes outside DECODE are ignored
        opcode = 3'b001;
        tick();
        check("glitch_exec_skz", W_SKZ);
        opcode = 3'b100;
        tick();
        check("glitch_fetch", W_FETCH);
        opcode = 3'b000;
        tick();
        check("glitch_decode", W_IDLE);
        opcode = 3'b010;
        tick();
        check("glitch_exec_add", W_ADD);
        opcode = 3'b000;
        tick();

        run_instr("skz", 3'b001, W_SKZ);
        run_instr("add", 3'b010, W_ADD);
        run_instr("and", 3'b011, W_AND);
        run_instr("xor", 3'b100, W_XOR);
        run_instr("lda", 3'b101, W_LDA);
        run_instr("sto", 3'b110, W_STO);
        run_instr("jmp", 3'b111, W_JMP);
        check("after_sweep_fetch", W_FETCH);

        // Reset asserted during EXEC of STO
        tick();
        opcode = 3'b110;
        tick();
        check("sto_exec", W_STO);
        rst_n = 1'b0;
        tick();
        check("rst_mid_exec", W_FETCH);
        rst_n = 1'b1;
        tick();
        check("rst_mid_exec_decode", W_IDLE);
        opcode = 3'b011;
        tick();
        check("post_rst_and", W_AND);
        tick();

        // HLT: Halt from EXEC onward regardless of opcode
        tick();
        opcode = 3'b000;
        tick();
        check("hlt_exec", W_HLT);
        for (int i = 0; i < 12; i++) begin
            opcode = 3'($urandom_range(0, 7));
            tick();
            check("halted_hold", W_HLT);
        end
        rst_n = 1'b0;
        tick();
        check("rst_from_halted", W_FETCH);
        rst_n = 1'b1;
        tick();
        check("rst_from_halted_decode", W_IDLE);
        opcode = 3'b111;
        tick();
        check("post_halt_jmp", W_JMP);
        tick();

`ifdef CTRL_SKZ_GATE_EN
        tick();
        opcode = 3'b001;
        zero   = 1'b0;
        tick();
        check("skz_gate_zero0", W_IDLE);
        zero = 1'b1;
        #1;
        check("skz_gate_zero1", W_SKZ);
        tick();
        check("skz_gate_next_fetch", W_FETCH);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
- Multi-cycle control unit of the 8-bit accumulator RISC CPU.
- Sequences every instruction through fetch, decode and execute phases.
- Decodes the 3-bit opcode into memory, accumulator, ALU, branch and halt strobes for the datapath.
- Sits between the instruction register field and the datapath muxes/enables.

Parameters:
- none (all encodings are fixed constants in the shared package)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, synchronous, active-low
- opcode  input  3  opcode field of the current instruction, valid by the end of the DECODE cycle
- jump  output  1  load PC from instruction address (JMP)
- skip  output  1  skip-if-zero request (SKZ); the datapath qualifies it with the accumulator zero flag
- memWrite  output  1  write accumulator to memory (STO)
- memRead  output  1  memory read: instruction fetch or operand fetch
- ACCwrite  output  1  accumulator write enable
- ALUtoACC  output  1  accumulator source select: 1 = ALU result, 0 = memory data
- ALU_OP  output  2  ALU function: 00 ADD, 01 AND, 10 XOR, 11 PASS
- Halt  output  1  processor halted

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-low (rst_n).
- FSM states:
  - FETCH, DECODE, EXEC, HALTED; 2-bit state register.
  - FETCH -> DECODE -> EXEC -> FETCH, one cycle each.
  - From EXEC, opcode HLT goes to HALTED instead.
  - HALTED is absorbing until reset.
- Reset:
  - rst_n sampled low at a rising edge: state = FETCH, ir_op = 000.
  - Reset has priority over every transition, including mid-EXEC and HALTED.
- Opcode latch: ir_op <= opcode on the edge leaving DECODE. opcode is ignored in all other states, so changes during FETCH or EXEC have no effect.
- Output timing: all outputs are combinational from state and ir_op only (Moore); there is no combinational path from opcode to any output.
- FETCH: memRead=1; all others 0; ALU_OP=00.
- DECODE: all outputs 0; ALU_OP=00.
- EXEC, by ir_op (unlisted outputs 0, ALU_OP=00 unless stated):
  - 000 HLT: Halt=1
  - 001 SKZ: skip=1
  - 010 ADD: memRead=1, ACCwrite=1, ALUtoACC=1, ALU_OP=00
  - 011 AND: memRead=1, ACCwrite=1, ALUtoACC=1, ALU_OP=01
  - 100 XOR: memRead=1, ACCwrite=1, ALUtoACC=1, ALU_OP=10
  - 101 LDA: memRead=1, ACCwrite=1, ALUtoACC=0, ALU_OP=11
  - 110 STO: memWrite=1
  - 111 JMP: jump=1
- HALTED: Halt=1; all other outputs 0.
- Output values after reset: state FETCH, so memRead=1 and jump, skip, memWrite, ACCwrite, ALUtoACC, Halt = 0, ALU_OP=00.
- Instruction latency: exactly 3 cycles per instruction. HLT asserts Halt in EXEC and in every following cycle.
- Exclusivity: memRead and memWrite are never both 1; jump and skip are never both 1.
- X-safety: an opcode containing X/Z at the latch edge decodes to the default all-zero control word; Halt is not asserted.

Optional Feature:
- Macro: CTRL_SKZ_GATE_EN.
- Defined:
  - Adds input port zero (1 bit, accumulator == 0).
  - skip = SKZ-in-EXEC AND zero, so the controller itself resolves the condition.
- Undefined:
  - No zero port.
  - skip is the unconditional SKZ request; the datapath performs the gating.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode constants OP_HLT..OP_JMP
  - ALU_OP constants ALU_ADD, ALU_AND, ALU_XOR, ALU_PASS
  - state enum (FETCH, DECODE, EXEC, HALTED)
  - packed control-word struct
- Sub-module ctrl_decode: purely combinational, ir_op -> control word. The top holds the FSM and the ir_op register, and masks the control word by state.

Test Plan:
- Reset: rst_n=0 for 2 edges, then release -> first cycle FETCH: memRead=1, Halt=0, ALU_OP=00; DECODE next cycle: all outputs 0.
- Opcode sweep: each opcode 001..111 presented in DECODE -> next cycle shows the exact EXEC word from the table. Example: 100 -> memRead=1, ACCwrite=1, ALUtoACC=1, ALU_OP=10. Then FETCH follows.
- Opcode glitch: opcode=001 during DECODE, changed to 100 mid-EXEC and to 000 in FETCH -> EXEC shows skip=1 only; the 000 is ignored because it arrives outside DECODE.
- Halt: opcode=000 latched -> Halt=1 in EXEC and stays 1 for 10+ cycles with all other outputs 0, whatever opcode does.
- Reset mid-operation: rst_n=0 during EXEC of STO, and separately while HALTED -> next cycle FETCH, memWrite=0, Halt=0.
- With CTRL_SKZ_GATE_EN: SKZ with zero=0 -> skip=0; SKZ with zero=1 -> skip=1 for exactly one cycle.
